// File: rtl/tconv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tconv_pkg
//  Description : Shared sequencer state encoding and default opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
package tconv_pkg;

   // Sequencer states; 3 bits cover the five states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_LOAD  = 3'd2,
      ST_MAC   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Instruction code that launches a computation unless overridden
   localparam logic [7:0] c_OPCODE_DEFAULT = 8'h03;

endpackage : tconv_pkg
`default_nettype wire

// File: rtl/wavefront_decode.sv
`default_nettype none
// ============================================================================
//  Module      : wavefront_decode
//  Description : Per-PE wavefront strobe decode from state, phase counter,
//                active PE count and latched iteration count. Also reports
//                whether the current cycle must hold (stall or backpressure)
//                and which PE, if any, ejects its result.
//  Revision    : 1.0 - initial release
// ============================================================================
module wavefront_decode
   import tconv_pkg::*;
#(
   parameter int NUM_PE = 16,
   parameter int ITER_W = 9,
   parameter int P_W    = ITER_W + $clog2(NUM_PE) + 1,
   parameter int AP_W   = $clog2(NUM_PE)
) (
   input  state_t              state_i,
   input  logic [P_W-1:0]      p_i,
   input  logic [ITER_W-1:0]   n_i,
   input  logic [AP_W-1:0]     active_pe_i,
   input  logic                stall_i,
   input  logic                out_ready_i,
   output logic [NUM_PE-1:0]   en_weight_load_o,
   output logic [NUM_PE-1:0]   en_ifmap_load_o,
   output logic [NUM_PE-1:0]   en_psum_o,
   output logic [NUM_PE-1:0]   clear_psum_o,
   output logic [NUM_PE-1:0]   en_output_o,
   output logic [NUM_PE-1:0]   ifmap_sel_ctrl_o,
   output logic                hold_o,
   output logic                fire_o,
   output logic [AP_W-1:0]     fire_idx_o
);

   logic [P_W-1:0]    w_n_ext;
   logic [NUM_PE-1:0] w_act;   // PE i has entered the wavefront (i <= active_pe)
   logic [NUM_PE-1:0] w_live;  // PE i still has iterations left (p < i+N)
   logic [NUM_PE-1:0] w_due;   // PE i ejects its result this phase (p == i+N)
   logic              w_any_due;

   assign w_n_ext   = {{(P_W-ITER_W){1'b0}}, n_i};
   assign w_any_due = |w_due;

   generate
      for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
         localparam logic [P_W-1:0] c_I = P_W'(i);
         if (i == 0) begin : g_act_first
            assign w_act[i] = 1'b1;
         end else begin : g_act_rest
            assign w_act[i] = (AP_W'(i) <= active_pe_i);
         end
         assign w_live[i] = w_act[i] && (p_i < (c_I + w_n_ext));
         assign w_due[i]  = (p_i == (c_I + w_n_ext));
      end
   endgenerate

   // Strobe decode per state; hold suppresses every load/compute/eject strobe
   always_comb begin
      en_weight_load_o = '0;
      en_ifmap_load_o  = '0;
      en_psum_o        = '0;
      clear_psum_o     = '0;
      en_output_o      = '0;
      ifmap_sel_ctrl_o = '0;
      hold_o           = 1'b0;
      fire_o           = 1'b0;
      fire_idx_o       = '0;
      for (int k = 0; k < NUM_PE; k++) begin
         if (w_due[k]) fire_idx_o = AP_W'(k);
      end
      case (state_i)
         ST_CLEAR: begin
            clear_psum_o = '1;
         end
         ST_LOAD: begin
            if (stall_i) begin
               hold_o = 1'b1;
            end else begin
               en_weight_load_o = w_live;
               en_ifmap_load_o  = w_live;
               ifmap_sel_ctrl_o = NUM_PE'(1);
            end
         end
         ST_MAC: begin
            // A due result that downstream cannot take freezes the whole array
            if (stall_i || (w_any_due && !out_ready_i)) begin
               hold_o = 1'b1;
            end else begin
               en_psum_o   = w_live;
               en_output_o = w_due;
               fire_o      = w_any_due;
            end
         end
         default: begin
         end
      endcase
   end

endmodule : wavefront_decode
`default_nettype wire

// File: rtl/wavefront_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : wavefront_mac_sequencer
//  Description : Drives a linear systolic array of NUM_PE MAC elements with a
//                diagonal wavefront: PE i starts one phase after PE i-1, runs
//                N iterations and ejects its partial sum at phase i+N.
//  Revision    : 1.0 - initial release
// ============================================================================
module wavefront_mac_sequencer
   import tconv_pkg::*;
#(
   parameter int         NUM_PE = 16,
   parameter int         ITER_W = 9,
   parameter logic [7:0] OPCODE = c_OPCODE_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [7:0]                    instr_code,
   input  logic [ITER_W-1:0]             num_iterations,
   input  logic                          stall,
   input  logic                          out_ready,
   output logic [NUM_PE-1:0]             en_weight_load,
   output logic [NUM_PE-1:0]             en_ifmap_load,
   output logic [NUM_PE-1:0]             en_psum,
   output logic [NUM_PE-1:0]             clear_psum,
   output logic [NUM_PE-1:0]             en_output,
   output logic [NUM_PE-1:0]             ifmap_sel_ctrl,
   output logic [$clog2(NUM_PE+1)-1:0]   done_idx,
   output logic [ITER_W-1:0]             iter_count,
   output logic                          busy,
   output logic                          done_pulse,
   output logic                          err_zero_iter
);

   // Phase counter reaches N+NUM_PE-1 at most; one spare bit rules out wrap
   localparam int c_P_W   = ITER_W + $clog2(NUM_PE) + 1;
   localparam int c_AP_W  = $clog2(NUM_PE);
   localparam int c_IDX_W = $clog2(NUM_PE+1);

   state_t              state_q, state_d;
   logic [c_P_W-1:0]    p_q, p_d;
   logic [c_AP_W-1:0]   active_pe_q, active_pe_d;
   logic [ITER_W-1:0]   n_q, n_d;
   logic [ITER_W-1:0]   iter_count_q, iter_count_d;
   logic [c_IDX_W-1:0]  done_idx_q, done_idx_d;
   logic                busy_q, busy_d;
   logic                done_pulse_q, done_pulse_d;
   logic                err_zero_q, err_zero_d;

   logic                w_hold;
   logic                w_fire;
   logic [c_AP_W-1:0]   w_fire_idx;
   logic                w_launch;
   logic [c_P_W-1:0]    w_p_last;

   assign w_launch = start && (instr_code == OPCODE);
   assign w_p_last = {{(c_P_W-ITER_W){1'b0}}, n_q} + c_P_W'(NUM_PE - 1);

   wavefront_decode #(
      .NUM_PE (NUM_PE),
      .ITER_W (ITER_W),
      .P_W    (c_P_W),
      .AP_W   (c_AP_W)
   ) u_decode (
      .state_i          (state_q),
      .p_i              (p_q),
      .n_i              (n_q),
      .active_pe_i      (active_pe_q),
      .stall_i          (stall),
      .out_ready_i      (out_ready),
      .en_weight_load_o (en_weight_load),
      .en_ifmap_load_o  (en_ifmap_load),
      .en_psum_o        (en_psum),
      .clear_psum_o     (clear_psum),
      .en_output_o      (en_output),
      .ifmap_sel_ctrl_o (ifmap_sel_ctrl),
      .hold_o           (w_hold),
      .fire_o           (w_fire),
      .fire_idx_o       (w_fire_idx)
   );

   // Next-state and register update decisions
   always_comb begin
      state_d      = state_q;
      p_d          = p_q;
      active_pe_d  = active_pe_q;
      n_d          = n_q;
      iter_count_d = iter_count_q;
      done_idx_d   = done_idx_q;
      done_pulse_d = 1'b0;
      err_zero_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_launch) begin
               if (num_iterations != '0) begin
                  state_d      = ST_CLEAR;
                  n_d          = num_iterations;
                  p_d          = '0;
                  active_pe_d  = '0;
                  iter_count_d = '0;
                  done_idx_d   = '0;
               end else begin
                  err_zero_d   = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (!w_hold) state_d = ST_MAC;
         end
         ST_MAC: begin
            if (!w_hold) begin
               p_d = p_q + 1'b1;
               if (iter_count_q != n_q) iter_count_d = iter_count_q + 1'b1;
               if (active_pe_q != c_AP_W'(NUM_PE - 1)) active_pe_d = active_pe_q + 1'b1;
               if (w_fire) done_idx_d = c_IDX_W'(w_fire_idx);
               if (p_q == w_p_last) begin
                  state_d      = ST_DONE;
                  done_pulse_d = 1'b1;
               end else begin
                  state_d      = ST_LOAD;
               end
            end
         end
         ST_DONE: begin
            done_idx_d = c_IDX_W'(NUM_PE);
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         p_q          <= '0;
         active_pe_q  <= '0;
         n_q          <= '0;
         iter_count_q <= '0;
         done_idx_q   <= '0;
         busy_q       <= 1'b0;
         done_pulse_q <= 1'b0;
         err_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         p_q          <= p_d;
         active_pe_q  <= active_pe_d;
         n_q          <= n_d;
         iter_count_q <= iter_count_d;
         done_idx_q   <= done_idx_d;
         busy_q       <= busy_d;
         done_pulse_q <= done_pulse_d;
         err_zero_q   <= err_zero_d;
      end
   end

   assign done_idx      = done_idx_q;
   assign iter_count    = iter_count_q;
   assign busy          = busy_q;
   assign done_pulse    = done_pulse_q;
   assign err_zero_iter = err_zero_q;

endmodule : wavefront_mac_sequencer
`default_nettype wire

// File: tb/tb_wavefront_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wavefront_mac_sequencer
//  Description : Directed self-checking bench: a 4-PE instance for schedule,
//                stall, backpressure, error and abort cases, and a default
//                16-PE instance for the long saturating run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wavefront_mac_sequencer;

   logic clk;
   logic rst;

   // 4-PE instance signals
   logic       start, stall, ordy;
   logic [7:0] instr;
   logic [8:0] niter;
   logic [3:0] wl, il, ps, cp, eo, sel;
   logic [2:0] didx;
   logic [8:0] itc;
   logic       busy, dpul, err;

   // 16-PE instance signals
   logic        s_start, s_stall, s_ordy;
   logic [7:0]  s_instr;
   logic [8:0]  s_niter;
   logic [15:0] s_wl, s_il, s_ps, s_cp, s_eo, s_sel;
   logic [4:0]  s_didx;
   logic [8:0]  s_itc;
   logic        s_busy, s_dpul, s_err;

   int total = 0;
   int bad   = 0;

   // per-run traces of the 4-PE instance
   int         oc[4];
   int         dpc, bfc;
   logic [3:0] wl_tr[64];
   logic [3:0] ps_tr[64];
   logic [3:0] cp_tr[64];
   logic [3:0] sel_tr[64];
   logic [3:0] eo_tr[64];

   wavefront_mac_sequencer #(.NUM_PE(4), .ITER_W(9), .OPCODE(8'h03)) dut (
      .clk(clk), .rst(rst), .start(start), .instr_code(instr),
      .num_iterations(niter), .stall(stall), .out_ready(ordy),
      .en_weight_load(wl), .en_ifmap_load(il), .en_psum(ps),
      .clear_psum(cp), .en_output(eo), .ifmap_sel_ctrl(sel),
      .done_idx(didx), .iter_count(itc), .busy(busy),
      .done_pulse(dpul), .err_zero_iter(err)
   );

   wavefront_mac_sequencer dut16 (
      .clk(clk), .rst(rst), .start(s_start), .instr_code(s_instr),
      .num_iterations(s_niter), .stall(s_stall), .out_ready(s_ordy),
      .en_weight_load(s_wl), .en_ifmap_load(s_il), .en_psum(s_ps),
      .clear_psum(s_cp), .en_output(s_eo), .ifmap_sel_ctrl(s_sel),
      .done_idx(s_didx), .iter_count(s_itc), .busy(s_busy),
      .done_pulse(s_dpul), .err_zero_iter(s_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // One 4-PE launch with N=3; cycle 0 carries start. Windows disabled by c=100.
   task automatic run4(input int st_c, input int st_n, input int bp_c, input int bp_n,
                       input bit zero_regs);
      for (int i = 0; i < 4; i++) oc[i] = -1;
      dpc = -1;
      bfc = -1;
      for (int c = 0; c < 60 && bfc < 0; c++) begin
         @(negedge clk);
         rst   = 1'b0;
         start = (c == 0);
         instr = 8'h03;
         niter = 9'd3;
         stall = (c >= st_c) && (c < st_c + st_n);
         ordy  = !((c >= bp_c) && (c < bp_c + bp_n));
         #1;
         wl_tr[c] = wl; ps_tr[c] = ps; cp_tr[c] = cp; sel_tr[c] = sel; eo_tr[c] = eo;
         for (int i = 0; i < 4; i++) if (eo[i] && oc[i] < 0) oc[i] = c;
         if (dpul && dpc < 0) dpc = c;
         if (dpc >= 0 && !busy && bfc < 0) bfc = c;
         if (c == 0) begin
            chk("idle_busy", busy, 0);
            chk("idle_strobes", {wl, il, ps, cp, eo, sel}, 0);
            if (zero_regs) begin
               chk("post_rst_iter", itc, 0);
               chk("post_rst_didx", didx, 0);
            end
         end
         if (stall) chk("stall_strobes", {wl, il, ps, cp, eo, sel}, 0);
      end
      start = 1'b0;
   endtask

   initial begin
      int mx, steps, nonseq, last_c, sdp, sbf;
      logic [4:0] prev;
      rst = 1'b1; start = 0; stall = 0; ordy = 1; instr = 8'h03; niter = 9'd3;
      s_start = 0; s_stall = 0; s_ordy = 1; s_instr = 8'h03; s_niter = 9'd256;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done_pulse", dpul, 0);
      chk("rst_err", err, 0);
      chk("rst_iter", itc, 0);
      chk("rst_didx", didx, 0);
      chk("rst_strobes", {wl, il, ps, cp, eo, sel}, 0);

      // nominal schedule
      run4(100, 0, 100, 0, 1'b1);
      chk("nom_out0", oc[0], 9);
      chk("nom_out1", oc[1], 11);
      chk("nom_out2", oc[2], 13);
      chk("nom_out3", oc[3], 15);
      chk("nom_done", dpc, 16);
      chk("nom_busy_fall", bfc, 17);
      chk("nom_clear_c1", cp_tr[1], 4'hF);
      chk("nom_wl_c2", wl_tr[2], 4'h1);
      chk("nom_sel_c2", sel_tr[2], 4'h1);
      chk("nom_psum_c3", ps_tr[3], 4'h1);
      chk("nom_wl_c6", wl_tr[6], 4'h7);
      chk("nom_wl_c8", wl_tr[8], 4'hE);
      chk("nom_psum_c9", ps_tr[9], 4'hE);
      chk("nom_eo_c10", eo_tr[10], 4'h0);
      chk("nom_wl_c14", wl_tr[14], 4'h0);
      chk("nom_iter_final", itc, 3);
      chk("nom_didx_final", didx, 4);

      // backpressure during cycles 11..13
      run4(100, 0, 11, 3, 1'b0);
      chk("bp_out0", oc[0], 9);
      chk("bp_out1", oc[1], 14);
      chk("bp_out2", oc[2], 16);
      chk("bp_out3", oc[3], 18);
      chk("bp_done", dpc, 19);
      chk("bp_busy_fall", bfc, 20);
      chk("bp_eo_c11", eo_tr[11], 4'h0);
      chk("bp_psum_c12", ps_tr[12], 4'h0);

      // stall for two cycles in LOAD at p=1
      run4(4, 2, 100, 0, 1'b0);
      chk("st_out0", oc[0], 11);
      chk("st_out1", oc[1], 13);
      chk("st_out2", oc[2], 15);
      chk("st_out3", oc[3], 17);
      chk("st_done", dpc, 18);
      chk("st_busy_fall", bfc, 19);
      chk("st_wl_c6", wl_tr[6], 4'h3);

      // zero iteration count rejected with an error pulse
      @(negedge clk); start = 1; instr = 8'h03; niter = 9'd0; #1;
      chk("zero_err_c0", err, 0);
      @(negedge clk); start = 0; #1;
      chk("zero_err_c1", err, 1);
      chk("zero_busy_c1", busy, 0);
      @(negedge clk); #1;
      chk("zero_err_c2", err, 0);
      chk("zero_busy_c2", busy, 0);

      // wrong opcode ignored
      @(negedge clk); start = 1; instr = 8'h05; niter = 9'd3;
      @(negedge clk); start = 0; #1;
      chk("opc_busy_c1", busy, 0);
      chk("opc_err_c1", err, 0);
      @(negedge clk); #1;
      chk("opc_strobes_c2", {wl, il, ps, cp, eo, sel}, 0);

      // abort with reset in MAC at p=2, then relaunch right after reset
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         start = (c == 0); instr = 8'h03; niter = 9'd3; stall = 0; ordy = 1;
         rst = (c == 7);
         #1;
         if (c == 7) chk("abort_psum_p2", ps, 4'h7);
         if (dpul) chk("abort_no_done", dpul, 0);
      end
      run4(100, 0, 100, 0, 1'b1);
      chk("re_out0", oc[0], 9);
      chk("re_out3", oc[3], 15);
      chk("re_done", dpc, 16);
      chk("re_busy_fall", bfc, 17);

      // 16 PEs, N=256
      mx = 0; steps = 0; nonseq = 0; last_c = -1; sdp = -1; sbf = -1;
      prev = s_didx;
      for (int c = 0; c < 700 && sbf < 0; c++) begin
         @(negedge clk);
         s_start = (c == 0); s_instr = 8'h03; s_niter = 9'd256;
         #1;
         if (int'(s_itc) > mx) mx = int'(s_itc);
         if (s_didx != prev) begin
            if (s_didx == prev + 5'd1) steps++;
            else nonseq++;
            prev = s_didx;
         end
         if (s_eo[15]) last_c = c;
         if (s_dpul && sdp < 0) sdp = c;
         if (sdp >= 0 && !s_busy && sbf < 0) sbf = c;
      end
      s_start = 0;
      chk("big_iter_max", mx, 256);
      chk("big_iter_final", s_itc, 256);
      chk("big_didx_steps", steps, 16);
      chk("big_didx_nonseq", nonseq, 0);
      chk("big_didx_final", s_didx, 16);
      chk("big_last_out", last_c, 545);
      chk("big_done", sdp, 546);
      chk("big_idle_strobes", {s_wl, s_il, s_ps, s_cp, s_eo, s_sel}, 0);
      chk("big_err", s_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_wavefront_mac_sequencer
`default_nettype wire

// File: doc/wavefront_mac_sequencer.md
WAVEFRONT_MAC_SEQUENCER -- requirements
Module: wavefront_mac_sequencer

Interface
REQ-001 Parameter NUM_PE, default 16: number of systolic PEs driven; legal range 2..64.
REQ-002 Parameter ITER_W, default 9: width of the iteration-count input.
REQ-003 Parameter OPCODE, default 8'h03: instruction code that launches a computation.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock, the only clock.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 start  in  1  launch request, sampled in IDLE only.
REQ-008 instr_code  in  8  instruction; launch only when equal to OPCODE.
REQ-009 num_iterations  in  ITER_W  MAC iterations per PE (N), latched at launch.
REQ-010 stall  in  1  freeze request: holds state, counters and all enables low.
REQ-011 out_ready  in  1  downstream accepts one PE result this cycle.
REQ-012 en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output, ifmap_sel_ctrl  out  NUM_PE each  per-PE strobes.
REQ-013 done_idx  out  $clog2(NUM_PE+1)  index of last ejected PE; NUM_PE means all ejected.
REQ-014 iter_count  out  ITER_W  saturating iteration counter.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done_pulse  out  1  one-cycle pulse in DONE.
REQ-017 err_zero_iter  out  1  one-cycle pulse when a launch is rejected because N = 0.

Function
REQ-018 States: IDLE, CLEAR, LOAD, MAC, DONE; internal registers are phase counter p, active_pe, latched N.
REQ-019 IDLE -> CLEAR when start and instr_code==OPCODE and num_iterations!=0; this latches N and clears p, active_pe, iter_count and done_idx.
REQ-020 When launched with num_iterations==0: stay in IDLE, pulse err_zero_iter next cycle; wrong opcode is ignored silently.
REQ-021 CLEAR: clear_psum all ones for one cycle -> LOAD; stall is ignored in CLEAR.
REQ-022 LOAD: for i<=active_pe with p < i+N, assert en_weight_load[i] and en_ifmap_load[i]; ifmap_sel_ctrl[0]=1, other bits 0; then -> MAC.
REQ-023 MAC: en_psum[i] for i<=active_pe with p < i+N; en_output[i] for the single i with p == i+N, gated by out_ready.
REQ-024 A MAC cycle with a due output and out_ready=0 is a backpressure stall: all enables are 0, no register changes, state remains MAC.
REQ-025 An unstalled MAC cycle: p+1; iter_count+1 saturating at N; active_pe+1 saturating at NUM_PE-1; if en_output[i] fired, done_idx<=i.
REQ-026 Unstalled MAC -> DONE when p == N+NUM_PE-1; otherwise -> LOAD.
REQ-027 stall=1 in LOAD or MAC: all enables 0, no state or counter change; stall takes priority over out_ready.
REQ-028 DONE: done_idx<=NUM_PE, done_pulse=1 -> IDLE; start during any busy state is ignored.
REQ-029 All per-PE strobes are combinational from state and registers; all other outputs are registered.
REQ-030 p width is ITER_W+$clog2(NUM_PE)+1; no wrap is possible for legal N.

Reset
REQ-031 On rst: state IDLE; p, active_pe, latched N, iter_count and done_idx are 0; busy, done_pulse and err_zero_iter are 0; all strobes are 0 from the next cycle.
REQ-032 rst mid-operation aborts the computation with no done_pulse; a start in the first cycle after reset is honoured.

Structure
REQ-033 State encoding and OPCODE default constants live in the shared package tconv_pkg.
REQ-034 The per-PE wavefront enable decode (active_pe, p, N -> enable vectors) is one sub-module, wavefront_decode, instantiated once.

Verification
REQ-035 NUM_PE=4, N=3, start at cycle 0, out_ready=1: en_output[0..3] fire at cycles 9, 11, 13 and 15; done_pulse at cycle 16; busy falls at cycle 17.
REQ-036 Same setup with out_ready=0 for cycles 11-13: en_output[1] fires at cycle 14 and done_pulse is delayed 3 cycles; the strobe sequence is otherwise unchanged.
REQ-037 stall=1 for 2 cycles during LOAD at p=1: all strobes 0 for those cycles and the whole schedule shifts by 2 cycles.
REQ-038 start with N=0: no state change, err_zero_iter=1 one cycle later; start with instr_code=8'h05: no response.
REQ-039 rst asserted at MAC p=2: the next cycle is IDLE with all outputs 0 and no done_pulse; a new start runs a full nominal schedule.
REQ-040 NUM_PE=16, N=256: iter_count saturates at 256; done_idx steps 0..15 and then reads 16; the last output occurs at p=271.
